// File: rtl/bp_pkg.sv
// ============================================================================
// bp_pkg: types and constants shared by the branch predictor and its
//         resolution unit.                                          rev 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam int unsigned BP_ADDR_BITS = 32;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [BP_ADDR_BITS-1:0] pc;
    logic                    taken;
    logic [BP_ADDR_BITS-1:0] target;
  } pred_entry_t;

endpackage

`default_nettype wire

// File: rtl/bru_pred_fifo.sv
// ============================================================================
// bru_pred_fifo: in-order prediction queue with flush; flush beats push.
//                                                                    rev 1.0
// ============================================================================
`default_nettype none

module bru_pred_fifo #(
  parameter int WIDTH      = 65,
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   count
);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr_q, rd_ptr_q;
  logic                do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty at equal index.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == (LOG2_DEPTH+1)'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + (LOG2_DEPTH+1)'(1);
      end
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
      end else if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (LOG2_DEPTH+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolution_unit.sv
// ============================================================================
// branch_resolution_unit: compares queued predictions with resolved outcomes,
//                         drives BHT updates and fetch redirects.  rev 1.0
// ============================================================================
`default_nettype none

module branch_resolution_unit
  import bp_pkg::*;
#(
  parameter int ADDRESS_BITS     = 32,
  parameter int QUEUE_DEPTH      = 8,
  parameter int LOG2_QUEUE_DEPTH = $clog2(QUEUE_DEPTH),
  parameter int CNT_WIDTH        = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pred_valid,
  output logic                        pred_ready,
  input  logic [ADDRESS_BITS-1:0]     pred_pc,
  input  logic                        pred_taken,
  input  logic [ADDRESS_BITS-1:0]     pred_target,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic                        res_taken,
  input  logic [ADDRESS_BITS-1:0]     res_target,
  output logic [6:0]                  update_opcode,
  output logic [ADDRESS_BITS-1:0]     update_pc,
  output logic                        actual_pred,
  output logic                        mispred,
  output logic                        redirect_valid,
  output logic [ADDRESS_BITS-1:0]     redirect_pc,
  output logic                        res_error,
  output logic [LOG2_QUEUE_DEPTH:0]   occupancy,
  output logic [CNT_WIDTH-1:0]        branch_count,
  output logic [CNT_WIDTH-1:0]        mispred_count
);

  localparam int ENTRY_W = 2*ADDRESS_BITS + 1;

  bru_state_e state_q, state_d;

  logic [ENTRY_W-1:0]      head;
  logic                    full, empty;
  logic                    push, resolve, mis, res_empty;
  logic [ADDRESS_BITS-1:0] head_pc, head_target, fix_pc;
  logic                    head_taken;

  logic [6:0]              update_opcode_q;
  logic [ADDRESS_BITS-1:0] update_pc_q, redirect_pc_q;
  logic                    actual_pred_q, mispred_q, redirect_valid_q, res_error_q;
  logic [CNT_WIDTH-1:0]    branch_count_q, mispred_count_q;

  assign pred_ready = (state_q == RUN) && !full;
  assign res_ready  = (state_q == RUN) && !empty;
  assign push       = pred_valid && pred_ready;
  assign resolve    = res_valid && res_ready;
  assign res_empty  = res_valid && (state_q == RUN) && empty;

  assign head_pc     = head[ENTRY_W-1 -: ADDRESS_BITS];
  assign head_taken  = head[ADDRESS_BITS];
  assign head_target = head[ADDRESS_BITS-1:0];

  // A taken branch to the wrong target is as costly as a wrong direction.
  assign mis    = (head_taken != res_taken) || (res_taken && (head_target != res_target));
  assign fix_pc = res_taken ? res_target : head_pc + ADDRESS_BITS'(4);

  bru_pred_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (QUEUE_DEPTH),
    .LOG2_DEPTH (LOG2_QUEUE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({pred_pc, pred_taken, pred_target}),
    .pop   (resolve),
    .flush (resolve && mis),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (resolve && mis) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= RUN;
      update_opcode_q  <= '0;
      update_pc_q      <= '0;
      actual_pred_q    <= 1'b0;
      mispred_q        <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      res_error_q      <= 1'b0;
      branch_count_q   <= '0;
      mispred_count_q  <= '0;
    end else begin
      state_q          <= state_d;
      update_opcode_q  <= resolve ? OPCODE_BRANCH : 7'b0;
      mispred_q        <= resolve && mis;
      redirect_valid_q <= resolve && mis;
      res_error_q      <= res_empty;
      if (resolve) begin
        update_pc_q   <= head_pc;
        actual_pred_q <= res_taken;
        if (branch_count_q != '1) branch_count_q <= branch_count_q + CNT_WIDTH'(1);
      end
      if (resolve && mis) begin
        redirect_pc_q <= fix_pc;
        if (mispred_count_q != '1) mispred_count_q <= mispred_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign update_opcode  = update_opcode_q;
  assign update_pc      = update_pc_q;
  assign actual_pred    = actual_pred_q;
  assign mispred        = mispred_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign res_error      = res_error_q;
  assign branch_count   = branch_count_q;
  assign mispred_count  = mispred_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolution_unit.sv
// ============================================================================
// tb_branch_resolution_unit: scoreboard bench for branch_resolution_unit.
//                                                                    rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [31:0] pred_pc = '0, pred_target = '0;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        pred_ready, res_ready, actual_pred, mispred, redirect_valid, res_error;
  logic [6:0]  update_opcode;
  logic [31:0] update_pc, redirect_pc, branch_count, mispred_count;
  logic [3:0]  occupancy;

  typedef struct {
    logic [31:0] pc;
    logic        act;
    logic        mis;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolution_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .update_opcode  (update_opcode),
    .update_pc      (update_pc),
    .actual_pred    (actual_pred),
    .mispred        (mispred),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .res_error      (res_error),
    .occupancy      (occupancy),
    .branch_count   (branch_count),
    .mispred_count  (mispred_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every update beat is matched against the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!reset) begin
      if (update_opcode != 7'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_update", 64'(update_opcode), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("update_opcode", 64'(update_opcode), 64'h63);
          chk("update_pc", 64'(update_pc), 64'(e.pc));
          chk("actual_pred", 64'(actual_pred), 64'(e.act));
          chk("mispred", 64'(mispred), 64'(e.mis));
          chk("redirect_valid", 64'(redirect_valid), 64'(e.mis));
          if (e.mis) chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
        end
      end else if (mispred || redirect_valid) begin
        chk("stray_redirect", 64'({mispred, redirect_valid}), 64'd0);
      end
    end
  end

  task automatic do_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    int n = 0;
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tg;
    while (!pred_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!pred_ready) chk("push_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    pred_valid = 1'b0;
  endtask

  // Resolve the head; optionally offer a push in the very same cycle.
  task automatic do_resolve(input logic tk, input logic [31:0] tg, input logic [31:0] e_pc,
                            input logic e_mis, input logic [31:0] e_rpc, input logic also_push);
    int n = 0;
    exp_t e;
    res_valid = 1'b1; res_taken = tk; res_target = tg;
    while (!res_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!res_ready) chk("resolve_timeout", 64'd0, 64'd1);
    e.pc = e_pc; e.act = tk; e.mis = e_mis; e.rpc = e_rpc;
    sb.push_back(e);
    if (also_push) begin
      pred_valid = 1'b1; pred_pc = 32'hDEAD_0000; pred_taken = 1'b0; pred_target = '0;
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    pred_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pred_ready", 64'(pred_ready), 64'd1);
    chk("rst_res_ready", 64'(res_ready), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_update_opcode", 64'(update_opcode), 64'd0);
    chk("rst_redirect", 64'({mispred, redirect_valid, res_error}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Correct not-taken prediction.
    do_push(32'h100, 1'b0, 32'h120);
    do_resolve(1'b0, 32'h0, 32'h100, 1'b0, 32'h0, 1'b0);
    // Direction mispredict: predicted not-taken, actually taken.
    do_push(32'h200, 1'b0, 32'h0);
    do_resolve(1'b1, 32'h240, 32'h200, 1'b1, 32'h240, 1'b0);
    chk("mispred_count_t2", 64'(mispred_count), 64'd1);
    // Target mispredict.
    do_push(32'h300, 1'b1, 32'h340);
    do_resolve(1'b1, 32'h380, 32'h300, 1'b1, 32'h380, 1'b0);
    // Predicted taken, actually falls through.
    do_push(32'h400, 1'b1, 32'h440);
    do_resolve(1'b0, 32'h0, 32'h400, 1'b1, 32'h404, 1'b0);
    chk("branch_count_t4", 64'(branch_count), 64'd4);
    chk("mispred_count_t4", 64'(mispred_count), 64'd3);

    // Fill the queue.
    for (int i = 0; i < 8; i++) do_push(32'h500 + 32'(i*4), 1'b0, 32'h0);
    chk("full_pred_ready", 64'(pred_ready), 64'd0);
    chk("full_occupancy", 64'(occupancy), 64'd8);
    do_resolve(1'b1, 32'h600, 32'h500, 1'b1, 32'h600, 1'b1);
    chk("recover_pred_ready", 64'(pred_ready), 64'd0);
    chk("recover_res_ready", 64'(res_ready), 64'd0);
    chk("recover_occupancy", 64'(occupancy), 64'd0);
    @(posedge clk); #1;
    chk("run_pred_ready", 64'(pred_ready), 64'd1);

    // Flush must beat an accepted same-cycle push.
    do_push(32'h700, 1'b1, 32'h740);
    do_resolve(1'b0, 32'h0, 32'h700, 1'b1, 32'h704, 1'b1);
    chk("flush_push_occupancy", 64'(occupancy), 64'd0);
    @(posedge clk); #1;
    chk("flush_push_after", 64'(occupancy), 64'd0);
    chk("branch_count_t5", 64'(branch_count), 64'd6);
    chk("mispred_count_t5", 64'(mispred_count), 64'd5);

    // Resolve with nothing queued.
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h900;
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("empty_res_error", 64'(res_error), 64'd1);
    chk("empty_no_update", 64'(update_opcode), 64'd0);
    chk("empty_branch_count", 64'(branch_count), 64'd6);
    @(posedge clk); #1;
    chk("res_error_pulse", 64'(res_error), 64'd0);

    // Asynchronous reset with entries in flight.
    for (int i = 0; i < 3; i++) do_push(32'hA00 + 32'(i*4), 1'b1, 32'hB00);
    chk("pre_reset_occupancy", 64'(occupancy), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_occupancy", 64'(occupancy), 64'd0);
    chk("async_branch_count", 64'(branch_count), 64'd0);
    chk("async_mispred_count", 64'(mispred_count), 64'd0);
    chk("async_res_ready", 64'(res_ready), 64'd0);
    chk("async_pred_ready", 64'(pred_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
